// File: rtl/task_scheduler.sv
// Instruction scheduler: validates RPi instructions, queues them, dispatches each
// to its task engine, muxes that engine's SRAM buses and aborts hung tasks.
module task_scheduler #(
  parameter int unsigned N              = 80,
  parameter int unsigned NUM_SRAM       = 4,
  parameter int unsigned NUM_ENGINES    = 2,
  parameter int unsigned QUEUE_DEPTH    = 4,
  parameter logic [23:0] MAX_ADDRESS    = 24'h1FFFF,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'hFFFFFF
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [N-1:0]                        RPi_inst,
  input  logic                                execute_task,
  output logic                                inst_valid,
  output logic                                inst_rejected,
  output logic                                idle,
  output logic                                task_done,
  output logic                                task_error,
  output logic [1:0]                          last_error,
  output logic [$clog2(QUEUE_DEPTH):0]        queue_count,
  output logic [NUM_ENGINES-1:0]              eng_execute,
  output logic [NUM_ENGINES-1:0]              eng_abort,
  input  logic [NUM_ENGINES-1:0]              eng_job_done,
  output logic [71:0]                         cur_address,
  input  logic [NUM_ENGINES*NUM_SRAM*8-1:0]   eng_inst,
  input  logic [NUM_ENGINES*NUM_SRAM*24-1:0]  eng_address,
  input  logic [NUM_ENGINES*NUM_SRAM-1:0]     eng_write_in,
  input  logic [NUM_ENGINES*NUM_SRAM*24-1:0]  eng_byte_length,
  output logic [NUM_SRAM*8-1:0]               inst,
  output logic [NUM_SRAM*24-1:0]              address,
  output logic [NUM_SRAM-1:0]                 write_in,
  output logic [NUM_SRAM*24-1:0]              byte_length
);

  localparam int unsigned OP_W      = 8;
  localparam int unsigned ADDR_W    = 24;
  localparam int unsigned CMD_W     = 3 * ADDR_W;
  localparam int unsigned PTR_W     = $clog2(QUEUE_DEPTH);
  localparam int unsigned CNT_W     = $clog2(QUEUE_DEPTH) + 1;
  localparam int unsigned SEL_W     = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;
  localparam int unsigned WD_W      = 24;
  localparam int unsigned INST_BW   = NUM_SRAM * 8;
  localparam int unsigned ADDR_BW   = NUM_SRAM * 24;
  localparam int unsigned WR_BW     = NUM_SRAM;
  localparam int unsigned LEN_BW    = NUM_SRAM * 24;
  localparam logic [OP_W-1:0] OP_MIN  = OP_W'(256 - NUM_ENGINES);
  localparam logic [WD_W-1:0] WD_LAST = TIMEOUT_CYCLES - WD_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_RUN, S_ABORT} state_t;

  typedef struct packed {
    logic [SEL_W-1:0] sel;
    logic [CMD_W-1:0] addr;
  } entry_t;

  state_t               state_q, state_d;
  logic [OP_W-1:0]      opcode;
  logic [ADDR_W-1:0]    addr0, addr1, addr2;
  logic                 push, pop;
  entry_t               fifo_mem [QUEUE_DEPTH];
  entry_t               head;
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [SEL_W-1:0]     sel_q, sel_d;
  logic [CMD_W-1:0]     cur_d;
  logic [WD_W-1:0]      wd_q, wd_d;
  logic [1:0]           last_error_d;
  logic [NUM_ENGINES-1:0] exec_d, abort_d;
  logic                 done_d, error_d, rejected_d;
  logic                 sel_done;

  // Instruction decode and legality check
  assign opcode = RPi_inst[N-1 -: OP_W];
  assign addr0  = RPi_inst[N-9 -: ADDR_W];
  assign addr1  = RPi_inst[N-33 -: ADDR_W];
  assign addr2  = RPi_inst[N-57 -: ADDR_W];

  assign inst_valid = (opcode != '0) && (opcode >= OP_MIN) &&
                      (addr0 <= MAX_ADDRESS) && (addr1 <= MAX_ADDRESS) &&
                      (addr2 <= MAX_ADDRESS);

  // A full queue refuses the push even if the head pops on the same edge
  assign push       = execute_task && inst_valid && (count_q < CNT_W'(QUEUE_DEPTH));
  assign rejected_d = execute_task && !push;

  assign head        = fifo_mem[rd_ptr];
  assign queue_count = count_q;
  assign idle        = (state_q == S_IDLE) && (count_q == '0);

  always_comb begin : count_next
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Completion from the selected engine only
  always_comb begin : done_select
    sel_done = 1'b0;
    for (int e = 0; e < int'(NUM_ENGINES); e++) begin
      if (sel_q == SEL_W'(e)) sel_done = eng_job_done[e];
    end
  end

  always_comb begin : fsm_next
    state_d      = state_q;
    sel_d        = sel_q;
    cur_d        = cur_address;
    wd_d         = wd_q;
    last_error_d = last_error;
    pop          = 1'b0;
    exec_d       = '0;
    abort_d      = '0;
    done_d       = 1'b0;
    error_d      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          pop          = 1'b1;
          sel_d        = head.sel;
          cur_d        = head.addr;
          wd_d         = '0;
          last_error_d = 2'b00;
          exec_d       = NUM_ENGINES'(1) << head.sel;
          state_d      = S_LAUNCH;
        end
      end
      S_LAUNCH: state_d = S_RUN;
      S_RUN: begin
        // Saturating watchdog; done has priority over timeout
        wd_d = (wd_q == '1) ? wd_q : wd_q + WD_W'(1);
        if (sel_done) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (wd_q == WD_LAST) begin
          abort_d      = NUM_ENGINES'(1) << sel_q;
          error_d      = 1'b1;
          last_error_d = 2'b01;
          state_d      = S_ABORT;
        end
      end
      S_ABORT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin : regs
    if (reset) begin
      state_q       <= S_IDLE;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count_q       <= '0;
      sel_q         <= '0;
      wd_q          <= '0;
      cur_address   <= '0;
      last_error    <= 2'b00;
      eng_execute   <= '0;
      eng_abort     <= '0;
      task_done     <= 1'b0;
      task_error    <= 1'b0;
      inst_rejected <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      sel_q         <= sel_d;
      wd_q          <= wd_d;
      cur_address   <= cur_d;
      last_error    <= last_error_d;
      eng_execute   <= exec_d;
      eng_abort     <= abort_d;
      task_done     <= done_d;
      task_error    <= error_d;
      inst_rejected <= rejected_d;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // Queue storage needs no reset; pointers and count define validity
  always_ff @(posedge clk) begin : fifo_write
    if (push) fifo_mem[wr_ptr] <= '{sel: SEL_W'(8'hFF - opcode), addr: {addr0, addr1, addr2}};
  end

  // SRAM command mux: selected engine's slice while a task is active, zero in IDLE
  always_comb begin : sram_mux
    inst        = '0;
    address     = '0;
    write_in    = '0;
    byte_length = '0;
    if (state_q != S_IDLE) begin
      for (int e = 0; e < int'(NUM_ENGINES); e++) begin
        if (sel_q == SEL_W'(e)) begin
          inst        = eng_inst[e*INST_BW +: INST_BW];
          address     = eng_address[e*ADDR_BW +: ADDR_BW];
          write_in    = eng_write_in[e*WR_BW +: WR_BW];
          byte_length = eng_byte_length[e*LEN_BW +: LEN_BW];
        end
      end
    end
  end

endmodule

// File: doc/task_scheduler.md
# task_scheduler

Parametrised successor to the single-task RPi accelerator manager. It validates RPi instructions, buffers accepted instructions in a FIFO, and dispatches each one to one of `NUM_ENGINES` task engines. While a task runs, it muxes that engine's SRAM command bus onto the `NUM_SRAM` SRAM controllers. A watchdog aborts hung tasks. The block sits between the RPi SPI instruction register and the SRAM controllers/task engines.

## Interface

**Parameters**
- `N`, 80: instruction width. Opcode is `[N-1:N-8]`; addr0/1/2 are the following three 24-bit fields, MSB first.
- `NUM_SRAM`, 4: number of SRAM channels.
- `NUM_ENGINES`, 2: number of engines. Engine k owns opcode `8'hFF-k`.
- `QUEUE_DEPTH`, 4: instruction FIFO depth (power of two, ≥2).
- `MAX_ADDRESS`, 24'h1FFFF: highest legal SRAM address.
- `TIMEOUT_CYCLES`, 24'hFFFFFF: RUN cycles allowed before abort.

**Ports**
- `clk`  in  1  clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `RPi_inst`  in  N  candidate instruction.
- `execute_task`  in  1  push request, sampled each cycle.
- `inst_valid`  out  1  combinational: `RPi_inst` is legal.
- `inst_rejected`  out  1  one-cycle pulse: push refused.
- `idle`  out  1  combinational: state IDLE and FIFO empty.
- `task_done`  out  1  one-cycle pulse: engine completed.
- `task_error`  out  1  one-cycle pulse: watchdog abort.
- `last_error`  out  2  00 none, 01 timeout; sticky until next dispatch.
- `queue_count`  out  $clog2(QUEUE_DEPTH)+1  FIFO occupancy.
- `eng_execute`  out  NUM_ENGINES  one-hot start pulse.
- `eng_abort`  out  NUM_ENGINES  one-hot abort pulse.
- `eng_job_done`  in  NUM_ENGINES  engine completion.
- `cur_address`  out  72  addr0..2 of the running task, packed {a0,a1,a2}.
- `eng_inst`, `eng_address`, `eng_write_in`, `eng_byte_length`  in  NUM_ENGINES×NUM_SRAM×{8,24,1,24}  per-engine SRAM command buses, packed engine-major.
- `inst`, `address`, `write_in`, `byte_length`  out  NUM_SRAM×{8,24,1,24}  SRAM command bus.

## Operation

**Validity**
- `inst_valid` = opcode ∈ [`8'hFF-NUM_ENGINES+1`, `8'hFF`] and each addr ≤ `MAX_ADDRESS` (unsigned).
- Opcode `8'h00` is never valid.

**Push**
- `execute_task` with `inst_valid` and `queue_count<QUEUE_DEPTH` (pre-edge value) → write to tail.
- Otherwise, if `execute_task` is high, pulse `inst_rejected`.
- A full FIFO rejects the push even when a pop occurs in the same cycle.

**FSM (`IDLE`, `LAUNCH`, `RUN`, `ABORT`)**
- `IDLE`: if FIFO non-empty → pop head; latch engine index (`8'hFF`-opcode) and `cur_address`; clear `last_error` and the watchdog; go to `LAUNCH`.
- `LAUNCH`: `eng_execute[sel]`=1 for this one cycle; go to `RUN`.
- `RUN`: watchdog increments each cycle.
  - `eng_job_done[sel]` → pulse `task_done`, go to `IDLE`.
  - Otherwise, if watchdog == `TIMEOUT_CYCLES`-1 → go to `ABORT`.
  - Done wins over timeout in the same cycle.
- `ABORT`: `eng_abort[sel]`=1, pulse `task_error`, set `last_error`=01; go to `IDLE`.

**Other rules**
- `eng_job_done` is ignored outside `RUN`, and for non-selected engines.
- SRAM bus mux: in `LAUNCH`, `RUN` or `ABORT`, the outputs carry the selected engine's slice. In `IDLE`, all SRAM outputs are 0.
- Watchdog is 24 bits and never wraps; it is cleared on dispatch.

## Timing

**Reset**
- Asynchronous: state `IDLE`, FIFO empty, `queue_count`=0.
- All pulses, `eng_execute`, `eng_abort`, `last_error`, `cur_address` = 0.
- `idle`=1 immediately.
- Reset mid-task drops the queue and the running task without pulsing `eng_abort`.

**Latency**
- Push at edge k → `idle` falls after edge k.
- Pop/dispatch at edge k+1.
- `eng_execute` high in cycle k+1..k+2.
- `RUN` from edge k+2.
- Earliest `task_done`: one cycle after `eng_job_done` is sampled in `RUN`.

**Back-to-back and output behaviour**
- Back-to-back tasks: `IDLE` lasts exactly one cycle between tasks when the FIFO is non-empty.
- `task_done`, `task_error`, `inst_rejected`, `eng_execute`, `eng_abort` are registered.

## Test plan

- Reset, then push opcode FF, addrs 0/0x100/0x1FFFF: `inst_valid`=1, `eng_execute`=01 pulse two cycles later, `cur_address` matches. Assert `eng_job_done[0]` → one `task_done` pulse, `idle`=1.
- Push opcode FE with addr 0x20000, then opcode 00: `inst_valid`=0, `inst_rejected` pulses twice, `queue_count` stays 0.
- With engine 0 stalled, push 5 valid instructions: `queue_count` = 4 (1 popped + 4 queued), 6th push rejected. Release done: tasks dispatch in FIFO order with one `IDLE` cycle between them.
- `TIMEOUT_CYCLES`=16, engine never done: `eng_abort[0]` + `task_error` 16 cycles after `RUN` entry, `last_error`=01, next dispatch clears it.
- `eng_job_done` and timeout coincide: `task_done`=1, `task_error`=0. Assert `reset` in `RUN`: all outputs 0 and `idle`=1 before the next edge.
